free_list_ctrl: RTL and testbench

Allocation controller for the rename-stage physical-register free list. Each cycle it decides which dispatch slots may pop a free PRN, drives the free list's `pop_en`, and stalls dispatch when too few registers are available. It also sequences branch-mispredict recovery: it pulses `rat_squash` so the RAT free list reloads the RRAT free-list snapshot, then holds dispatch for a programmable settle window. It sits between dispatch and `rat_free_list`, and keeps a shadow occupancy count because the RAT free list exports no counter.

---
 rtl/free_list_ctrl.sv | 155 +++++++++++++++
 tb/tb_free_list_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/free_list_ctrl.sv
// Rename-stage allocation controller for the physical-register free list.
// Grants in-order pops against a shadow occupancy count and sequences mispredict recovery.
module free_list_ctrl #(
  parameter int N                   = 3,
  parameter int SIZE                = 64,  // PHYS_REG_SZ_R10K
  parameter int RECOVER_CYCLES      = 1,
  parameter int FREE_LIST_CTR_WIDTH = $clog2(SIZE + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0]                   alloc_req,
  input  logic [N-1:0]                   free_valid,
  input  logic                           squash_req,
  input  logic [FREE_LIST_CTR_WIDTH-1:0] rrat_counter,
  output logic [N-1:0]                   pop_en,
  output logic [N-1:0]                   alloc_grant,
  output logic                           dispatch_stall,
  output logic                           rat_squash,
  output logic [FREE_LIST_CTR_WIDTH-1:0] avail_count,
  output logic                           recovering
);

  localparam int CW = FREE_LIST_CTR_WIDTH;
  localparam int RW = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;

  localparam logic [CW:0]   SIZE_X   = (CW + 1)'(SIZE);
  localparam logic [CW:0]   ONE_X    = (CW + 1)'(1);
  localparam logic [RW-1:0] REC_INIT = RW'(RECOVER_CYCLES);
  localparam logic [RW-1:0] REC_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_SQUASH  = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [RW-1:0]   rcnt_q;
  logic            rat_squash_q;
  logic            recovering_q;

  logic [N-1:0]    grant;
  logic            blocked;
  logic [CW:0]     granted;
  logic [CW:0]     sum_x;
  logic [CW:0]     rrat_x;

  function automatic logic [CW:0] popcnt(input logic [N-1:0] v);
    logic [CW:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) c = c + ONE_X;
    end
    return c;
  endfunction

  // In-order prefix grant: the first refused requester blocks every younger slot.
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    granted = '0;
    if (!reset && state_q == S_NORMAL && !squash_req) begin
      for (int i = 0; i < N; i++) begin
        if (alloc_req[i]) begin
          // NOTE: blocking assignments here are intentional; each slot must see the
          // running grant total left by the earlier slots within the same evaluation.
          if (!blocked && granted < {1'b0, count_q}) begin
            grant[i] = 1'b1;
            granted  = granted + ONE_X;
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end
  end

  assign pop_en         = grant;
  assign alloc_grant    = grant;
  assign dispatch_stall = reset | (state_q != S_NORMAL) | squash_req | (|(alloc_req & ~grant));

  // Evaluated one bit wider so pops/pushes cannot wrap before the full-list clamp.
  always_comb begin
    sum_x   = {1'b0, count_q} - popcnt(grant) + popcnt(free_valid);
    rrat_x  = {1'b0, rrat_counter};
    count_d = count_q;
    if (state_q == S_SQUASH) begin
      count_d = (rrat_x > SIZE_X) ? SIZE_X[CW-1:0] : rrat_counter;
    end else begin
      count_d = (sum_x > SIZE_X) ? SIZE_X[CW-1:0] : sum_x[CW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_NORMAL;
      count_q      <= SIZE_X[CW-1:0];
      rcnt_q       <= '0;
      rat_squash_q <= 1'b0;
      recovering_q <= 1'b0;
    end else begin
      count_q <= count_d;
      case (state_q)
        S_NORMAL: begin
          if (squash_req) begin
            state_q      <= S_SQUASH;
            rat_squash_q <= 1'b1;
            recovering_q <= 1'b1;
          end
        end
        S_SQUASH: begin
          if (squash_req) begin
            state_q      <= S_SQUASH;
            rat_squash_q <= 1'b1;
            recovering_q <= 1'b1;
          end else if (RECOVER_CYCLES == 0) begin
            state_q      <= S_NORMAL;
            rat_squash_q <= 1'b0;
            recovering_q <= 1'b0;
          end else begin
            state_q      <= S_RECOVER;
            rcnt_q       <= REC_INIT;
            rat_squash_q <= 1'b0;
            recovering_q <= 1'b1;
          end
        end
        S_RECOVER: begin
          if (squash_req) begin
            state_q      <= S_SQUASH;
            rat_squash_q <= 1'b1;
            recovering_q <= 1'b1;
          end else if (rcnt_q <= REC_ONE) begin
            state_q      <= S_NORMAL;
            rcnt_q       <= '0;
            recovering_q <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q - REC_ONE;
          end
        end
        default: begin
          state_q      <= S_NORMAL;
          rat_squash_q <= 1'b0;
          recovering_q <= 1'b0;
        end
      endcase
    end
  end

  assign rat_squash  = rat_squash_q;
  assign recovering  = recovering_q;
  assign avail_count = count_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl with N=3, SIZE=8, RECOVER_CYCLES=1.
// Inputs change #1 after the rising edge; outputs are sampled before the next edge.
module tb_free_list_ctrl;

  localparam int N  = 3;
  localparam int SZ = 8;
  localparam int CW = $clog2(SZ + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  alloc_req;
  logic [N-1:0]  free_valid;
  logic          squash_req;
  logic [CW-1:0] rrat_counter;
  logic [N-1:0]  pop_en;
  logic [N-1:0]  alloc_grant;
  logic          dispatch_stall;
  logic          rat_squash;
  logic [CW-1:0] avail_count;
  logic          recovering;

  int n_checks = 0;
  int n_fail   = 0;

  free_list_ctrl #(
    .N(N), .SIZE(SZ), .RECOVER_CYCLES(1)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .free_valid(free_valid),
    .squash_req(squash_req), .rrat_counter(rrat_counter),
    .pop_en(pop_en), .alloc_grant(alloc_grant),
    .dispatch_stall(dispatch_stall), .rat_squash(rat_squash),
    .avail_count(avail_count), .recovering(recovering)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] fv,
                       input logic sq, input logic [CW-1:0] rr);
    alloc_req    = req;
    free_valid   = fv;
    squash_req   = sq;
    rrat_counter = rr;
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [N-1:0] g, input logic st);
    check({tag, "_grant"}, 32'(alloc_grant), 32'(g));
    check({tag, "_pop"},   32'(pop_en),      32'(g));
    check({tag, "_stall"}, 32'(dispatch_stall), 32'(st));
  endtask

  initial begin
    reset = 1'b1;
    drive(3'b111, 3'b000, 1'b0, '0);
    chk_grant("in_reset", 3'b000, 1'b1);
    tick();
    check("rst_avail", 32'(avail_count), 8);
    check("rst_recov", 32'(recovering), 0);
    check("rst_squash", 32'(rat_squash), 0);
    chk_grant("in_reset2", 3'b000, 1'b1);

    // Three cycles of full requests drain 8 -> 5 -> 2 -> 0.
    reset = 1'b0;
    drive(3'b111, 3'b000, 1'b0, '0);
    chk_grant("burst0", 3'b111, 1'b0);
    tick();
    check("burst1_avail", 32'(avail_count), 5);
    chk_grant("burst1", 3'b111, 1'b0);
    tick();
    check("burst2_avail", 32'(avail_count), 2);
    chk_grant("burst2", 3'b011, 1'b1);
    tick();
    check("burst3_avail", 32'(avail_count), 0);

    // Refill to 1, then the in-order prefix rule with a gap slot.
    drive(3'b000, 3'b001, 1'b0, '0);
    chk_grant("idle", 3'b000, 1'b0);
    tick();
    check("one_avail", 32'(avail_count), 1);
    drive(3'b101, 3'b000, 1'b0, '0);
    chk_grant("gap101", 3'b001, 1'b1);
    tick();
    check("empty_avail", 32'(avail_count), 0);
    drive(3'b110, 3'b011, 1'b0, '0);
    chk_grant("empty_req", 3'b000, 1'b1);
    tick();
    check("push_avail", 32'(avail_count), 2);

    // Climb to 7, then an extra push is clamped at SIZE.
    drive(3'b000, 3'b111, 1'b0, '0);
    tick();
    check("fill5", 32'(avail_count), 5);
    drive(3'b000, 3'b011, 1'b0, '0);
    tick();
    check("fill7", 32'(avail_count), 7);
    drive(3'b000, 3'b111, 1'b0, '0);
    tick();
    check("clamp8", 32'(avail_count), 8);

    // Single squash, rrat_counter=6, pushes during SQUASH ignored and in RECOVER counted.
    drive(3'b111, 3'b000, 1'b1, '0);
    chk_grant("sq_t", 3'b000, 1'b1);
    check("sq_t_pulse", 32'(rat_squash), 0);
    tick();
    drive(3'b111, 3'b001, 1'b0, 4'd6);
    check("sq_t1_pulse", 32'(rat_squash), 1);
    check("sq_t1_recov", 32'(recovering), 1);
    check("sq_t1_avail", 32'(avail_count), 8);
    chk_grant("sq_t1", 3'b000, 1'b1);
    tick();
    drive(3'b111, 3'b001, 1'b0, 4'd6);
    check("sq_t2_pulse", 32'(rat_squash), 0);
    check("sq_t2_recov", 32'(recovering), 1);
    check("sq_t2_avail", 32'(avail_count), 6);
    chk_grant("sq_t2", 3'b000, 1'b1);
    tick();
    drive(3'b111, 3'b000, 1'b0, 4'd6);
    check("sq_t3_avail", 32'(avail_count), 7);
    check("sq_t3_recov", 32'(recovering), 0);
    chk_grant("sq_t3", 3'b111, 1'b0);
    tick();
    check("sq_t4_avail", 32'(avail_count), 4);

    // Re-squash from RECOVER; second reload uses an illegal rrat value that must clamp.
    drive(3'b000, 3'b000, 1'b1, '0);
    tick();
    drive(3'b000, 3'b000, 1'b0, 4'd3);
    check("dsq_t1_pulse", 32'(rat_squash), 1);
    tick();
    drive(3'b000, 3'b000, 1'b1, 4'd3);
    check("dsq_t2_pulse", 32'(rat_squash), 0);
    check("dsq_t2_recov", 32'(recovering), 1);
    check("dsq_t2_avail", 32'(avail_count), 3);
    tick();
    drive(3'b001, 3'b000, 1'b0, 4'd12);
    check("dsq_t3_pulse", 32'(rat_squash), 1);
    chk_grant("dsq_t3", 3'b000, 1'b1);
    tick();
    drive(3'b001, 3'b000, 1'b0, 4'd12);
    check("dsq_t4_pulse", 32'(rat_squash), 0);
    check("dsq_t4_recov", 32'(recovering), 1);
    check("dsq_t4_avail", 32'(avail_count), 8);
    tick();
    drive(3'b001, 3'b000, 1'b0, 4'd12);
    check("dsq_t5_recov", 32'(recovering), 0);
    chk_grant("dsq_t5", 3'b001, 1'b0);
    tick();
    check("dsq_t6_avail", 32'(avail_count), 7);

    // Reset while in SQUASH aborts recovery.
    drive(3'b000, 3'b000, 1'b1, 4'd2);
    tick();
    drive(3'b000, 3'b000, 1'b0, 4'd2);
    check("rsq_pulse", 32'(rat_squash), 1);
    reset = 1'b1;
    tick();
    check("rsq_pulse_off", 32'(rat_squash), 0);
    check("rsq_recov", 32'(recovering), 0);
    check("rsq_avail", 32'(avail_count), 8);
    reset = 1'b0;
    drive(3'b011, 3'b000, 1'b0, 4'd2);
    chk_grant("rsq_normal", 3'b011, 1'b0);
    tick();
    check("rsq_no_pulse", 32'(rat_squash), 0);
    check("rsq_avail2", 32'(avail_count), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
